// File: rtl/sync_hs_arbiter.sv
// rtl/sync_hs_arbiter.sv - round-robin arbiter sharing one sync_handshake CDC channel
module sync_hs_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                           clk_source,
   input  logic                           rst_n_source,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic                           sig_pulse_source,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] sig_data_source,
   input  logic                           sync_busy,
   output logic                           done_valid,
   output logic [ID_WIDTH-1:0]            done_id,
   output logic                           err_protocol,
   output logic                           err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_ARM,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                         state, state_nxt;
   logic [ID_WIDTH-1:0]            rr_ptr, rr_ptr_nxt;
   logic [CW-1:0]                  busy_cnt, busy_cnt_nxt;
   logic [NUM_REQ-1:0]             req_ack_nxt;
   logic                           pulse_nxt;
   logic [ID_WIDTH+DATA_WIDTH-1:0] data_nxt;
   logic                           done_valid_nxt;
   logic [ID_WIDTH-1:0]            done_id_nxt;
   logic                           err_protocol_nxt;
   logic                           err_timeout_nxt;

   logic                           win_found;
   logic [ID_WIDTH-1:0]            win_id;
   logic [DATA_WIDTH-1:0]          win_data;
   logic [NUM_REQ-1:0]             win_onehot;

   // Two passes give the rr_ptr+1 .. rr_ptr wrap order: indices above the pointer first.
   always_comb begin
      win_found  = 1'b0;
      win_id     = '0;
      win_data   = '0;
      win_onehot = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req_valid[j] && (ID_WIDTH'(j) > rr_ptr)) begin
            win_found     = 1'b1;
            win_id        = ID_WIDTH'(j);
            win_data      = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            win_onehot[j] = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!win_found && req_valid[j] && (ID_WIDTH'(j) <= rr_ptr)) begin
            win_found     = 1'b1;
            win_id        = ID_WIDTH'(j);
            win_data      = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            win_onehot[j] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      rr_ptr_nxt       = rr_ptr;
      busy_cnt_nxt     = busy_cnt;
      req_ack_nxt      = '0;
      pulse_nxt        = 1'b0;
      data_nxt         = sig_data_source;
      done_valid_nxt   = 1'b0;
      done_id_nxt      = done_id;
      err_protocol_nxt = err_protocol;
      err_timeout_nxt  = err_timeout;
      case (state)
         S_IDLE: begin
            if (win_found && !sync_busy) begin
               rr_ptr_nxt  = win_id;
               data_nxt    = {win_id, win_data};
               pulse_nxt   = 1'b1;
               req_ack_nxt = win_onehot;
               state_nxt   = S_LAUNCH;
            end
         end
         S_LAUNCH: state_nxt = S_ARM;
         S_ARM: begin
            if (sync_busy) begin
               busy_cnt_nxt = '0;
               state_nxt    = S_BUSY;
            end else begin
               err_protocol_nxt = 1'b1;
               done_valid_nxt   = 1'b1;
               done_id_nxt      = rr_ptr;
               state_nxt        = S_DONE;
            end
         end
         S_BUSY: begin
            if (sync_busy) begin
               if (busy_cnt != CW'(TIMEOUT))
                  busy_cnt_nxt = busy_cnt + 1'b1;
               // Flag only; the channel is left to finish on its own.
               if (busy_cnt >= CW'(TIMEOUT - 1))
                  err_timeout_nxt = 1'b1;
            end else begin
               done_valid_nxt = 1'b1;
               done_id_nxt    = rr_ptr;
               state_nxt      = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_source or negedge rst_n_source) begin
      if (!rst_n_source) begin
         state            <= S_IDLE;
         rr_ptr           <= ID_WIDTH'(NUM_REQ - 1);
         busy_cnt         <= '0;
         req_ack          <= '0;
         sig_pulse_source <= 1'b0;
         sig_data_source  <= '0;
         done_valid       <= 1'b0;
         done_id          <= '0;
         err_protocol     <= 1'b0;
         err_timeout      <= 1'b0;
      end else begin
         state            <= state_nxt;
         rr_ptr           <= rr_ptr_nxt;
         busy_cnt         <= busy_cnt_nxt;
         req_ack          <= req_ack_nxt;
         sig_pulse_source <= pulse_nxt;
         sig_data_source  <= data_nxt;
         done_valid       <= done_valid_nxt;
         done_id          <= done_id_nxt;
         err_protocol     <= err_protocol_nxt;
         err_timeout      <= err_timeout_nxt;
      end
   end

endmodule

// File: tb/tb_sync_hs_arbiter.sv
// tb/tb_sync_hs_arbiter.sv - directed bench for sync_hs_arbiter
module tb_sync_hs_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;
   localparam int TO = 8;

   logic              clk_source   = 1'b0;
   logic              rst_n_source = 1'b0;
   logic [NR-1:0]     req_valid    = '0;
   logic [NR*DW-1:0]  req_data     = '0;
   logic              sync_busy    = 1'b0;
   logic [NR-1:0]     req_ack;
   logic              sig_pulse_source;
   logic [IW+DW-1:0]  sig_data_source;
   logic              done_valid;
   logic [IW-1:0]     done_id;
   logic              err_protocol;
   logic              err_timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk_source = ~clk_source;

   sync_hs_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .ID_WIDTH  (IW),
      .TIMEOUT   (TO)
   ) dut (
      .clk_source      (clk_source),
      .rst_n_source    (rst_n_source),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_ack         (req_ack),
      .sig_pulse_source(sig_pulse_source),
      .sig_data_source (sig_data_source),
      .sync_busy       (sync_busy),
      .done_valid      (done_valid),
      .done_id         (done_id),
      .err_protocol    (err_protocol),
      .err_timeout     (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk_source);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pulse"}, 32'(sig_pulse_source), 0);
      chk({tag, " ack"}, 32'(req_ack), 0);
      chk({tag, " data"}, 32'(sig_data_source), 0);
      chk({tag, " done_valid"}, 32'(done_valid), 0);
      chk({tag, " done_id"}, 32'(done_id), 0);
      chk({tag, " err_protocol"}, 32'(err_protocol), 0);
      chk({tag, " err_timeout"}, 32'(err_timeout), 0);
   endtask

   // Waits for a launch, plays the channel for blen busy cycles, checks completion.
   task automatic xfer(input string tag, input int wait_exp, input int blen,
                       input logic [IW-1:0] eid, input logic [DW-1:0] edata, input logic drop);
      int n;
      logic [NR-1:0] exp_ack;
      n = 0;
      exp_ack = 4'b0001 << eid;
      while (sig_pulse_source !== 1'b1 && n < 50) begin
         tick;
         n++;
      end
      if (wait_exp >= 0) chk({tag, " wait"}, n, wait_exp);
      chk({tag, " pulse"}, 32'(sig_pulse_source), 1);
      chk({tag, " ack"}, 32'(req_ack), 32'(exp_ack));
      chk({tag, " data"}, 32'(sig_data_source), 32'({eid, edata}));
      if (drop) req_valid[eid] = 1'b0;
      tick;
      chk({tag, " pulse_1cyc"}, 32'(sig_pulse_source), 0);
      chk({tag, " ack_1cyc"}, 32'(req_ack), 0);
      sync_busy = (blen > 0);
      for (int i = 1; i <= blen; i++) begin
         tick;
         if (blen > TO && i == 5) chk({tag, " tmo_early"}, 32'(err_timeout), 0);
      end
      chk({tag, " done_early"}, 32'(done_valid), 0);
      if (blen > TO) chk({tag, " tmo_set"}, 32'(err_timeout), 1);
      sync_busy = 1'b0;
      tick;
      chk({tag, " done_valid"}, 32'(done_valid), 1);
      chk({tag, " done_id"}, 32'(done_id), 32'(eid));
   endtask

   initial begin
      int n;
      tick;
      chk_all_zero("reset");
      rst_n_source = 1'b1;

      req_data  = 32'h000000A5;
      req_valid = 4'b0001;
      xfer("single", 1, 6, 2'd0, 8'hA5, 1'b1);
      chk("single err_protocol", 32'(err_protocol), 0);
      chk("single err_timeout", 32'(err_timeout), 0);
      tick;
      chk("single done_1cyc", 32'(done_valid), 0);

      rst_n_source = 1'b0;
      tick;
      rst_n_source = 1'b1;
      req_data  = 32'h3C965AC3;
      req_valid = 4'b1111;
      xfer("rr0", 1, 3, 2'd0, 8'hC3, 1'b0);
      xfer("rr1", 2, 1, 2'd1, 8'h5A, 1'b0);
      xfer("rr2", 2, 5, 2'd2, 8'h96, 1'b0);
      xfer("rr3", 2, 2, 2'd3, 8'h3C, 1'b0);
      xfer("rr4", 2, 4, 2'd0, 8'hC3, 1'b1);
      req_valid = '0;
      tick;

      sync_busy = 1'b1;
      req_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("gate no_pulse", 32'(sig_pulse_source), 0);
         chk("gate no_ack", 32'(req_ack), 0);
      end
      sync_busy = 1'b0;
      xfer("gate", 1, 2, 2'd2, 8'h96, 1'b1);

      chk("pre_proto err_protocol", 32'(err_protocol), 0);
      req_valid = 4'b1000;
      xfer("proto", 2, 0, 2'd3, 8'h3C, 1'b1);
      chk("proto err_protocol", 32'(err_protocol), 1);
      req_valid = 4'b0001;
      xfer("after_proto", 2, 2, 2'd0, 8'hC3, 1'b1);
      chk("after_proto sticky", 32'(err_protocol), 1);
      chk("after_proto err_timeout", 32'(err_timeout), 0);

      req_valid = 4'b0010;
      xfer("tmo", 2, 20, 2'd1, 8'h5A, 1'b1);
      tick;
      tick;
      chk("tmo sticky", 32'(err_timeout), 1);

      req_valid = 4'b0100;
      n = 0;
      while (sig_pulse_source !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      chk("arst launch", 32'(sig_pulse_source), 1);
      tick;
      sync_busy = 1'b1;
      tick;
      tick;
      tick;
      #2 rst_n_source = 1'b0;
      #1 chk_all_zero("arst");
      sync_busy = 1'b0;
      req_valid = 4'b1111;
      tick;
      rst_n_source = 1'b1;
      xfer("post_rst", 1, 1, 2'd0, 8'hC3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/sync_hs_arbiter.md
# sync_hs_arbiter

Source-domain arbiter that shares one `sync_handshake` CDC channel between NUM_REQ requesters. It picks one pending requester round-robin and launches a single-cycle `sig_pulse_source` with that requester's data, tagged with its ID. It then follows the channel's `sync_busy` to completion and reports which transfer finished. It sits in `clk_source`, directly in front of the channel's source-side ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: payload width per requester.
- `ID_WIDTH`, 2: requester ID width; must satisfy 2^ID_WIDTH >= NUM_REQ.
- `TIMEOUT`, 255: `sync_busy` high-time (cycles) beyond which `err_timeout` sets; must be >= 1.

- `clk_source`  in  1  clock of the source domain; the block's only clock.
- `rst_n_source`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request level; bit i held until `req_ack[i]`.
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while `req_valid[i]` is high.
- `req_ack`  out  NUM_REQ  one-hot, 1-cycle pulse: requester's data launched.
- `sig_pulse_source`  out  1  to channel; 1-cycle launch pulse.
- `sig_data_source`  out  ID_WIDTH+DATA_WIDTH  to channel; {id, data}, ID in MSBs.
- `sync_busy`  in  1  from channel; handshake in progress, valid in `clk_source`.
- `done_valid`  out  1  1-cycle pulse: transfer completed.
- `done_id`  out  ID_WIDTH  ID of the completed transfer, valid with `done_valid`.
- `err_protocol`  out  1  sticky: channel failed to raise `sync_busy` after a launch.
- `err_timeout`  out  1  sticky: `sync_busy` stayed high longer than TIMEOUT.

## Operation
- The FSM has five states: IDLE, LAUNCH, ARM, BUSY, DONE. All outputs are registered.
- **IDLE**
  - If any `req_valid` is high and `sync_busy`=0: pick winner w round-robin, latch {w, data_w} into `sig_data_source`, set `rr_ptr`=w, go to LAUNCH.
  - Otherwise stay in IDLE.
  - Requests arriving while `sync_busy`=1 wait; IDLE never launches while the channel is busy.
- **Round-robin order:** search rr_ptr+1, rr_ptr+2, ..., rr_ptr, wrapping modulo NUM_REQ. `rr_ptr` resets to NUM_REQ-1, so requester 0 has first priority.
- **LAUNCH** (1 cycle): `sig_pulse_source`=1 and `req_ack[w]`=1. Go to ARM.
- **ARM** (1 cycle)
  - `sync_busy`=1: go to BUSY and clear `busy_cnt`.
  - `sync_busy`=0: set `err_protocol` and go to DONE.
- **BUSY**
  - Increment `busy_cnt` each cycle, saturating at TIMEOUT.
  - When `busy_cnt` reaches TIMEOUT while `sync_busy` is still 1: set `err_timeout`. The block keeps waiting; it never aborts the channel.
  - `sync_busy`=0: go to DONE.
- **DONE** (1 cycle): `done_valid`=1, `done_id`=w. Go to IDLE.
- `sig_data_source` holds its value from LAUNCH until the next launch. The channel latches it on the pulse.
- `req_valid` is sampled only in IDLE. A requester must drop or replace its request before the next IDLE cycle after its ack, or it is granted again.
- `req_valid` bits at index >= NUM_REQ do not exist. IDs are zero-extended to ID_WIDTH.
- Error flags are cleared only by reset.

## Timing
- **Reset values:** state IDLE, `rr_ptr`=NUM_REQ-1, `busy_cnt`=0. `sig_pulse_source`, `req_ack`, `done_valid`, `done_id`, `sig_data_source`, `err_protocol` and `err_timeout` all reset to 0.
- **Launch latency:** requester i valid in IDLE at cycle N with `sync_busy`=0 gives `sig_pulse_source` and `req_ack[i]` in cycle N+1.
- **ARM check:** the channel raises `sync_busy` in cycle N+2, which ARM checks.
- **Completion:** first cycle with `sync_busy`=0 at cycle M (BUSY) gives `done_valid` at M+1. The next grant decision is made at M+2 (IDLE).
- **Throughput:** minimum spacing between launches is 4 + B cycles, where B is the number of `sync_busy`-high cycles.
- **Simultaneous requests:** exactly one grant per IDLE decision, never two acks at once.
- **Reset mid-transfer:** asynchronous assertion returns the FSM to IDLE and clears all outputs immediately. The channel must be reset in the same event; the system guarantees this.

## Test plan
- **Single request:** after reset, `req_valid`=4'b0001, data0=8'hA5; channel busy for 6 cycles -> `sig_pulse_source` for 1 cycle with `sig_data_source`=10'h0A5, `req_ack`=0001, then `done_valid` with `done_id`=0 one cycle after busy falls.
- **Round-robin fairness:** `req_valid`=4'b1111 held (re-asserted after each ack) -> grant order 0,1,2,3,0; `done_id` follows the same order; never two acks together.
- **Busy gating:** hold `sync_busy`=1 externally in IDLE with `req_valid`=4'b0100 -> no pulse; release busy -> pulse with ID 2 in the cycle after the release is seen in IDLE.
- **Protocol error:** channel stub never raises `sync_busy` -> `err_protocol`=1 two cycles after the pulse, `done_valid` follows, and the FSM returns to IDLE and serves the next request.
- **Timeout:** TIMEOUT=8, busy held 20 cycles -> `err_timeout` sets after 8 BUSY cycles and stays set; `done_valid` still occurs when busy falls.
- **Async reset during BUSY:** deassert `rst_n_source` mid-handshake -> all outputs 0 without waiting for a clock edge; after release, requester 0 is granted first.
